// File: rtl/alarm_qsys_onchip_memory_dp_pkg.sv
// alarm_qsys_mem_pkg: shared types and constants for the dual-port on-chip memory
package alarm_qsys_mem_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int LAT_COMB = 1;
    localparam int LAT_REG = 2;
    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/alarm_qsys_onchip_memory_dp_if.sv
// alarm_qsys_onchip_memory_dp_if: one Avalon-MM slave port of the dual-port memory
interface alarm_qsys_onchip_memory_dp_if
    import alarm_qsys_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] address;
    logic chipselect;
    logic read;
    logic write;
    logic [lanes(DATA_WIDTH)-1:0] byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic readdatavalid;
    logic waitrequest;
    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input readdata, readdatavalid, waitrequest
    );
    modport slave (
        input address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/alarm_qsys_onchip_memory_dp_core.sv
// alarm_qsys_ram_dp_core: true-dual-port RAM, per-lane write enables, read-first outputs
module alarm_qsys_ram_dp_core
    import alarm_qsys_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    localparam int LANES = lanes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [LANES-1:0]      we_a,
    input  logic                  re_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [LANES-1:0]      we_b,
    input  logic                  re_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic [DATA_WIDTH-1:0] q_b
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // outputs only move on a read so readdata holds between reads
    always_ff @(posedge clk) begin
        if (reset) q_a <= '0;
        else if (re_a) q_a <= mem[addr_a];
        if (reset) q_b <= '0;
        else if (re_b) q_b <= mem[addr_b];
        for (int k = 0; k < LANES; k++) begin
            if (we_a[k]) mem[addr_a][k*8 +: 8] <= wdata_a[k*8 +: 8];
            if (we_b[k]) mem[addr_b][k*8 +: 8] <= wdata_b[k*8 +: 8];
        end
    end
endmodule

// File: rtl/alarm_qsys_onchip_memory_dp.sv
// alarm_qsys_onchip_memory_dp: dual Avalon-MM slave RAM with clear engine,
// write-collision arbitration and 1/2-cycle read pipelines
module alarm_qsys_onchip_memory_dp
    import alarm_qsys_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic reset_req,
    alarm_qsys_onchip_memory_dp_if.slave s1,
    alarm_qsys_onchip_memory_dp_if.slave s2,
    output logic clear_busy
);
    localparam int LANES = lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    state_t state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic en, busy, hold, coll, acc1, acc2, rd1, rd2, clr_we;
    logic [LANES-1:0] we_a, we_b;
    logic [DATA_WIDTH-1:0] q1, q2, r1, r2;
    logic [1:0] v1, v2;

    assign en = clken & ~reset_req;
    assign busy = state == CLEAR;
    assign hold = reset | busy | ~en;
    assign coll = s1.chipselect & s1.write & s2.chipselect & s2.write & (s1.address == s2.address);
    assign s1.waitrequest = hold;
    assign s2.waitrequest = hold | coll;
    assign acc1 = s1.chipselect & (s1.read | s1.write) & ~hold;
    assign acc2 = s2.chipselect & (s2.read | s2.write) & ~(hold | coll);
    assign rd1 = acc1 & s1.read & ~s1.write;
    assign rd2 = acc2 & s2.read & ~s2.write;
    assign clr_we = busy & en & ~reset;
    assign clear_busy = reset ? (CLEAR_ON_RESET != 0) : busy;
    assign we_a = clr_we ? '1 : (acc1 & s1.write) ? s1.byteenable : '0;
    assign we_b = (acc2 & s2.write) ? s2.byteenable : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
            clr_addr <= '0;
        end else if (clr_we) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == LAST) state <= RUN;
        end
    end

    // port A is borrowed by the clear engine; s1 is held off meanwhile
    alarm_qsys_ram_dp_core #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_core (
        .clk(clk),
        .reset(reset),
        .addr_a(busy ? clr_addr : s1.address),
        .we_a(we_a),
        .re_a(rd1),
        .wdata_a(busy ? CLEAR_VALUE : s1.writedata),
        .q_a(q1),
        .addr_b(s2.address),
        .we_b(we_b),
        .re_b(rd2),
        .wdata_b(s2.writedata),
        .q_b(q2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            v2 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (en) begin
            v1 <= {v1[0], rd1};
            v2 <= {v2[0], rd2};
            if (v1[0]) r1 <= q1;
            if (v2[0]) r2 <= q2;
        end
    end

    assign s1.readdatavalid = (READ_LATENCY == LAT_REG ? v1[1] : v1[0]) & en & ~reset;
    assign s2.readdatavalid = (READ_LATENCY == LAT_REG ? v2[1] : v2[0]) & en & ~reset;
    assign s1.readdata = READ_LATENCY == LAT_REG ? r1 : q1;
    assign s2.readdata = READ_LATENCY == LAT_REG ? r2 : q2;
endmodule

// File: tb/tb_alarm_qsys_onchip_memory_dp.sv
// tb_alarm_qsys_onchip_memory_dp: READ_LATENCY 1 and 2 instances driven in lockstep
// against a queue-based reference model of the memory
module tb_alarm_qsys_onchip_memory_dp;
    typedef struct {
        logic [31:0] d;
        int due;
    } pend_t;

    logic clk = 0, reset, clken, reset_req;
    logic [3:0] addr [2];
    logic cs [2], rd [2], wr [2];
    logic [3:0] be [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [4];
    logic rdv [4], wreq [4], cbusy [2];
    logic [31:0] last [4];
    logic [31:0] mem [16];
    pend_t pq [4][$];
    int clr, tick, total, passed;

    always #5 clk = ~clk;

    alarm_qsys_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia1 ();
    alarm_qsys_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia2 ();
    alarm_qsys_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib1 ();
    alarm_qsys_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib2 ();

    assign {ia1.address, ia1.chipselect, ia1.read, ia1.write, ia1.byteenable, ia1.writedata} = {addr[0], cs[0], rd[0], wr[0], be[0], wd[0]};
    assign {ia2.address, ia2.chipselect, ia2.read, ia2.write, ia2.byteenable, ia2.writedata} = {addr[1], cs[1], rd[1], wr[1], be[1], wd[1]};
    assign {ib1.address, ib1.chipselect, ib1.read, ib1.write, ib1.byteenable, ib1.writedata} = {addr[0], cs[0], rd[0], wr[0], be[0], wd[0]};
    assign {ib2.address, ib2.chipselect, ib2.read, ib2.write, ib2.byteenable, ib2.writedata} = {addr[1], cs[1], rd[1], wr[1], be[1], wd[1]};
    assign {rdata[0], rdv[0], wreq[0]} = {ia1.readdata, ia1.readdatavalid, ia1.waitrequest};
    assign {rdata[1], rdv[1], wreq[1]} = {ia2.readdata, ia2.readdatavalid, ia2.waitrequest};
    assign {rdata[2], rdv[2], wreq[2]} = {ib1.readdata, ib1.readdatavalid, ib1.waitrequest};
    assign {rdata[3], rdv[3], wreq[3]} = {ib2.readdata, ib2.readdatavalid, ib2.waitrequest};

    alarm_qsys_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(ia1), .s2(ia2), .clear_busy(cbusy[0])
    );
    alarm_qsys_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(ib1), .s2(ib2), .clear_busy(cbusy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 0; rd[p] = 0; wr[p] = 0; addr[p] = 0; be[p] = 0; wd[p] = 0;
        end
    endtask

    task automatic req(input int p, input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        cs[p] = 1; rd[p] = r; wr[p] = w; addr[p] = a; wd[p] = d; be[p] = b;
    endtask

    // one clock: compare outputs at the falling edge, then advance the model on the rising edge
    task automatic step();
        logic en_m, busy, hold, coll, ev;
        logic acc [2];
        pend_t e;
        @(negedge clk);
        en_m = clken & ~reset_req;
        busy = clr < 16;
        hold = reset | busy | ~en_m;
        coll = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("waitrequest[%0d]", i), {31'd0, wreq[i]}, {31'd0, hold | (i % 2 == 1 && coll)});
            ev = en_m & ~reset & (pq[i].size() > 0 && pq[i][0].due == tick);
            check($sformatf("readdatavalid[%0d]", i), {31'd0, rdv[i]}, {31'd0, ev});
            if (ev) begin
                check($sformatf("readdata[%0d]", i), rdata[i], pq[i][0].d);
                last[i] = rdata[i];
            end
        end
        for (int d = 0; d < 2; d++) check($sformatf("clear_busy[%0d]", d), {31'd0, cbusy[d]}, {31'd0, reset | busy});
        for (int p = 0; p < 2; p++) acc[p] = cs[p] & (rd[p] | wr[p]) & ~(hold | (p == 1 && coll));
        @(posedge clk);
        if (reset) begin
            clr = 0;
            for (int i = 0; i < 4; i++) pq[i].delete();
        end else if (en_m) begin
            if (busy) begin
                mem[clr] = 32'h0;
                clr++;
            end
            for (int i = 0; i < 4; i++)
                if (pq[i].size() > 0 && pq[i][0].due == tick) void'(pq[i].pop_front());
            for (int p = 0; p < 2; p++)
                if (acc[p] & rd[p] & ~wr[p]) begin
                    e.d = mem[addr[p]];
                    e.due = tick + 1;
                    pq[p].push_back(e);
                    e.due = tick + 2;
                    pq[p + 2].push_back(e);
                end
            for (int p = 0; p < 2; p++)
                if (acc[p] & wr[p])
                    for (int k = 0; k < 4; k++)
                        if (be[p][k]) mem[addr[p]][k*8 +: 8] = wd[p][k*8 +: 8];
            tick++;
        end
        #1;
    endtask

    task automatic clear_all_last();
        for (int i = 0; i < 4; i++) last[i] = 32'h0;
    endtask

    initial begin
        int ncl;
        total = 0; passed = 0; clr = 0; tick = 0;
        for (int a = 0; a < 16; a++) mem[a] = 32'h0;
        clear_all_last();
        reset = 1; clken = 1; reset_req = 0;
        idle();
        @(posedge clk);
        #1;
        step();
        for (int i = 0; i < 4; i++) check($sformatf("reset_readdata[%0d]", i), rdata[i], 32'h0);
        reset = 0;

        ncl = 0;
        for (int n = 0; n < 20; n++) begin
            if (cbusy[0] && cbusy[1]) ncl++;
            step();
        end
        check("clear_len", ncl, 16);
        for (int a = 0; a < 16; a++) begin
            req(0, 1, 0, 4'(a), 32'h0, 4'h0);
            step();
        end
        idle();
        repeat (3) step();

        clear_all_last();
        req(0, 0, 1, 4'd5, 32'hDEADBEEF, 4'hF); step();
        req(0, 1, 0, 4'd5, 32'h0, 4'h0); step();
        idle(); repeat (3) step();
        check("beef_lat1", last[0], 32'hDEADBEEF);
        check("beef_lat2", last[2], 32'hDEADBEEF);

        req(0, 0, 1, 4'd3, 32'h11223344, 4'hF); step();
        req(0, 0, 1, 4'd3, 32'hAABBCCDD, 4'b0101); step();
        req(0, 1, 0, 4'd3, 32'h0, 4'h0); step();
        idle(); repeat (3) step();
        check("lanes_lat1", last[0], 32'h11BB33DD);
        check("lanes_lat2", last[2], 32'h11BB33DD);

        req(0, 0, 1, 4'd7, 32'h1, 4'hF);
        req(1, 0, 1, 4'd7, 32'h2, 4'hF);
        #1 check("collision_wait", {31'd0, wreq[1]}, 32'd1);
        step();
        cs[0] = 0; rd[0] = 0; wr[0] = 0;
        #1 check("collision_retry", {31'd0, wreq[1]}, 32'd0);
        step();
        idle();
        req(1, 1, 0, 4'd7, 32'h0, 4'h0); step();
        idle(); repeat (3) step();
        check("collision_lat1", last[1], 32'h2);
        check("collision_lat2", last[3], 32'h2);

        clear_all_last();
        req(0, 1, 0, 4'd5, 32'h0, 4'h0); step();
        idle(); clken = 0;
        repeat (3) step();
        check("freeze_pending", last[2], 32'h0);
        clken = 1;
        repeat (3) step();
        check("freeze_data", last[2], 32'hDEADBEEF);

        req(0, 1, 0, 4'd5, 32'h0, 4'h0); step();
        idle(); reset = 1; step();
        reset = 0;
        for (int n = 0; n < 20 && clr < 9; n++) step();
        check("clr_at_9", clr, 9);
        reset = 1; step();
        reset = 0;
        ncl = 0;
        for (int n = 0; n < 20; n++) begin
            if (cbusy[0] && cbusy[1]) ncl++;
            step();
        end
        check("reclear_len", ncl, 16);

        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                cs[p] = $urandom_range(0, 3) != 0;
                rd[p] = $urandom_range(0, 1) == 1;
                wr[p] = $urandom_range(0, 2) == 0;
                addr[p] = 4'($urandom_range(0, 15));
                be[p] = 4'($urandom_range(0, 15));
                wd[p] = $urandom;
            end
            if ($urandom_range(0, 1) == 1) addr[1] = addr[0];
            clken = $urandom_range(0, 9) != 0;
            reset_req = $urandom_range(0, 19) == 0;
            reset = $urandom_range(0, 199) == 0;
            step();
        end
        idle(); reset = 0; clken = 1; reset_req = 0;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
